panxi_pc_gen: RTL and testbench
===============================

# panxi_pc_gen

Parametrised program-counter generator that replaces the fixed-width, always-+4 PC register at the head of the IFU. It adds a configurable reset vector, a trap redirect ranked above jumps, a valid/ready fetch handshake, 16-bit (compressed) increments, and a small return-address stack (RAS) that predicts `ret` targets. It sits between the execute/CSR redirect sources and the instruction-fetch stage.

## Interface
- `DW`, 32, PC width in bits.
- `RST_VEC`, 32'h0, PC value loaded by either reset.
- `C_EXT`, 1, 1 enables +2 steps for 16-bit instructions; 0 forces +4.
- `RAS_DEPTH`, 4, RAS entries; power of two, 2..16.
- `clk`  in  1  single clock domain.
- `rst`  in  1  asynchronous, active-high reset.
- `rst_jtag_xi`  in  1  synchronous debug reset; same effect as `rst`, applied on the clock edge.
- `trap_en_xi`  in  1  trap/exception redirect request.
- `trap_addr_xi`  in  DW  trap target.
- `jmp_en_xi`  in  1  branch/jump redirect (execute-stage resolution).
- `jmp_addr_xi`  in  DW  jump target.
- `hold_xi`  in  1  pipeline hold; freezes sequential advance.
- `fetch_ready_xi`  in  1  IFU accepts the current `pc_xo`.
- `ilen16_xi`  in  1  the accepted instruction is 16-bit; ignored when `C_EXT=0`.
- `call_xi`  in  1  the accepted instruction is a call; push the return address.
- `ret_xi`  in  1  the accepted instruction is a return; pop the predicted target.
- `pc_xo`  out  DW  current fetch PC.
- `pc_valid_xo`  out  1  `pc_xo` is valid for fetch.
- `ras_cnt_xo`  out  $clog2(RAS_DEPTH)+1  live RAS entries (debug/perf).

## Operation
- States:
  - BOOT: entered on either reset.
    - `pc_xo=RST_VEC`, `pc_valid_xo=0`, RAS empty.
    - Moves unconditionally to RUN on the next clock.
  - RUN: `pc_valid_xo=1`.
- Accept condition: `acc = pc_valid_xo & fetch_ready_xi & ~hold_xi`.
- Next-PC priority, highest first. All updates are registered.
  1. Reset (`rst` or `rst_jtag_xi`) → `RST_VEC`, state BOOT.
  2. `trap_en_xi` → `trap_addr_xi`.
  3. `jmp_en_xi` → `jmp_addr_xi`.
  4. `acc & ret_xi` with RAS non-empty → RAS top.
  5. `acc` → `pc_xo + step`.
     - `step = 2` when `C_EXT & ilen16_xi`, else 4.
     - Addition is modulo 2^DW and wraps silently.
  6. Otherwise hold `pc_xo`.
- Redirects (items 2 and 3) override `hold_xi` and are legal in BOOT; a redirect in BOOT still moves the state to RUN.
- Alignment: redirect and RAS targets have bit 0 cleared. When `C_EXT=0`, bits [1:0] are cleared.
- RAS behaviour:
  - Updates only on `acc` and only when no trap or jump redirect occurs in the same cycle; a redirect takes precedence and suppresses the RAS update.
  - Push value: `pc_xo + step`.
  - Pop on empty: no state change; the sequential path is used.
  - Push when full: circular overwrite of the oldest entry; the count saturates at `RAS_DEPTH`.
  - `call_xi & ret_xi` together: the pop target is used as next PC, then the top entry is replaced by the push value; count unchanged (empty case: count becomes 1).
  - Trap does not clear the RAS. Only resets clear it.

## Timing
- Redirect asserted in cycle N → `pc_xo` equals the target in N+1; `pc_valid_xo` stays 1.
- Accept in cycle N → new PC in N+1, so back-to-back fetch runs at one PC per cycle.
- When `fetch_ready_xi=0` or `hold_xi=1`, `pc_xo` is stable until acceptance.
- Reset timing:
  - Asynchronous `rst` takes effect immediately.
  - `rst_jtag_xi` takes effect at the next edge.
  - Either reset drops `pc_valid_xo` in its first cycle.
  - First valid PC appears one cycle after the reset is released.
  - Reset mid-operation discards the pending redirect and RAS contents.
- Reset values: `pc_xo=RST_VEC`, `pc_valid_xo=0`, `ras_cnt_xo=0`.

## Structure
- Shared defines header holds:
  - `PANXI_DW`
  - `PANXI_RST_VEC`
  - the state encoding (`PC_BOOT`, `PC_RUN`)
- Sub-module `panxi_ras`:
  - Parameters `DW`, `RAS_DEPTH`.
  - Ports: push, pop, push data, top, count, sync clear.
  - Circular pointer plus saturating count.
- `panxi_pc_gen` contains the state register, priority mux, step adder and alignment logic.

## Test plan
- Reset sequencing (`RST_VEC=32'h8000_0000`): release `rst` with `fetch_ready_xi=1` → one cycle `pc_valid_xo=0`, then `8000_0000`, `8000_0004`, `8000_0008`.
- Redirect priority: `trap_en_xi` (`0x100`) and `jmp_en_xi` (`0x200`) asserted together under `hold_xi=1` → next `pc_xo=0x100`. `jmp_addr_xi=0x203` → `pc_xo=0x202`.
- Compressed steps: at PC `0x10`, accepts with `ilen16_xi` = 1, 0, 1 → PCs `0x12`, `0x16`, `0x18`. With `C_EXT=0`, the same stimulus gives `0x14`, `0x18`, `0x1C`.
- RAS:
  - Calls at `0x40` and `0x80` (4-byte), then `ret` at `0x300` → next PC `0x84`; second `ret` → `0x44`; third `ret` on empty → `pc+4`, `ras_cnt_xo=0`.
  - Pushing 5 times with `RAS_DEPTH=4` → count 4; the oldest return address is lost.
- Stall/wrap: `fetch_ready_xi=0` for 3 cycles → `pc_xo` unchanged. Accepting from PC `0xFFFF_FFFC` → `0x0000_0000`.
- `rst_jtag_xi` pulse mid-run with 2 RAS entries → `pc_xo=RST_VEC` at the next edge, `ras_cnt_xo=0`, `pc_valid_xo` low for one cycle.

Source files
------------

// File: rtl/panxi_pc_gen_pkg.sv
// panxi_pc_gen shared definitions
// default widths, reset vector and PC state encoding
package panxi_pc_gen_pkg;

  localparam int unsigned PANXI_DW = 32;
  localparam logic [PANXI_DW-1:0] PANXI_RST_VEC = 32'h0;

  typedef enum logic {
    PC_BOOT = 1'b0,
    PC_RUN  = 1'b1
  } pc_state_e;

endpackage

// File: rtl/panxi_pc_gen_ras.sv
// panxi_ras: return-address stack
// circular pointer with saturating count; full push overwrites oldest
module panxi_ras #(
  parameter int unsigned DW        = 32,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr,
  input  logic                         push,
  input  logic                         pop,
  input  logic [DW-1:0]                push_data,
  output logic [DW-1:0]                top,
  output logic [$clog2(RAS_DEPTH):0]   cnt
);

  localparam int unsigned PW = $clog2(RAS_DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [DW-1:0] mem [RAS_DEPTH];
  logic [PW-1:0] ptr_q;
  logic [PW-1:0] top_idx;
  logic [CW-1:0] cnt_q;
  logic          pop_ok;
  logic          full;

  assign top_idx = ptr_q - PW'(1);
  assign top     = mem[top_idx];
  assign cnt     = cnt_q;
  assign pop_ok  = pop & (cnt_q != '0);
  assign full    = (cnt_q == CW'(RAS_DEPTH));

  // pointer and count; push+pop replaces top in place
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else if (clr) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else if (push && pop_ok) begin
      ptr_q <= ptr_q;
      cnt_q <= cnt_q;
    end else if (push) begin
      ptr_q <= ptr_q + PW'(1);
      if (!full)
        cnt_q <= cnt_q + CW'(1);
    end else if (pop_ok) begin
      ptr_q <= ptr_q - PW'(1);
      cnt_q <= cnt_q - CW'(1);
    end
  end

  // entry storage; contents need no reset, count gates use
  always_ff @(posedge clk) begin
    if (!clr) begin
      if (push && pop_ok)
        mem[top_idx] <= push_data;
      else if (push)
        mem[ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/panxi_pc_gen.sv
// panxi_pc_gen: IFU program-counter generator
// reset vector, trap/jump redirect, fetch handshake, RAS prediction
module panxi_pc_gen
  import panxi_pc_gen_pkg::*;
#(
  parameter int unsigned   DW        = PANXI_DW,
  parameter logic [DW-1:0] RST_VEC   = PANXI_RST_VEC,
  parameter int unsigned   C_EXT     = 1,
  parameter int unsigned   RAS_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rst_jtag_xi,
  input  logic                       trap_en_xi,
  input  logic [DW-1:0]              trap_addr_xi,
  input  logic                       jmp_en_xi,
  input  logic [DW-1:0]              jmp_addr_xi,
  input  logic                       hold_xi,
  input  logic                       fetch_ready_xi,
  input  logic                       ilen16_xi,
  input  logic                       call_xi,
  input  logic                       ret_xi,
  output logic [DW-1:0]              pc_xo,
  output logic                       pc_valid_xo,
  output logic [$clog2(RAS_DEPTH):0] ras_cnt_xo
);

  pc_state_e     state_q;
  pc_state_e     state_nxt;
  logic [DW-1:0] pc_q;
  logic [DW-1:0] pc_nxt;
  logic [DW-1:0] step;
  logic [DW-1:0] pc_seq;
  logic [DW-1:0] ras_top;
  logic          acc;
  logic          ras_live;
  logic          ras_en;
  logic          ras_push;
  logic          ras_pop;

  function automatic logic [DW-1:0] align(
    input logic [DW-1:0] a
  );
    logic [DW-1:0] r;
    r = a;
    r[0] = 1'b0;
    if (C_EXT == 0)
      r[1] = 1'b0;
    return r;
  endfunction

  assign pc_xo       = pc_q;
  assign pc_valid_xo = (state_q == PC_RUN);
  assign acc         = pc_valid_xo & fetch_ready_xi & ~hold_xi;
  assign step        = ((C_EXT != 0) && ilen16_xi) ? DW'(2) : DW'(4);
  assign pc_seq      = pc_q + step;
  assign ras_live    = (ras_cnt_xo != '0);

  // RAS moves only on a plain accept, never alongside a redirect
  assign ras_en   = acc & ~trap_en_xi & ~jmp_en_xi & ~rst_jtag_xi;
  assign ras_push = ras_en & call_xi;
  assign ras_pop  = ras_en & ret_xi & ras_live;

  panxi_ras #(
    .DW        (DW),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .clr       (rst_jtag_xi),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (pc_seq),
    .top       (ras_top),
    .cnt       (ras_cnt_xo)
  );

  // next-PC priority mux: debug reset, trap, jump, ret, step, hold
  always_comb begin
    state_nxt = PC_RUN;
    pc_nxt    = pc_q;
    if (rst_jtag_xi) begin
      state_nxt = PC_BOOT;
      pc_nxt    = RST_VEC;
    end else if (trap_en_xi) begin
      pc_nxt = align(trap_addr_xi);
    end else if (jmp_en_xi) begin
      pc_nxt = align(jmp_addr_xi);
    end else if (acc && ret_xi && ras_live) begin
      pc_nxt = align(ras_top);
    end else if (acc) begin
      pc_nxt = pc_seq;
    end
  end

  // state and PC registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= PC_BOOT;
      pc_q    <= RST_VEC;
    end else begin
      state_q <= state_nxt;
      pc_q    <= pc_nxt;
    end
  end

endmodule

// File: tb/tb_panxi_pc_gen.sv
// tb_panxi_pc_gen: scoreboard bench for panxi_pc_gen
// two instances (C_EXT=1 and C_EXT=0) share stimulus
module tb_panxi_pc_gen;

  localparam logic [31:0] RV  = 32'h8000_0000;
  localparam int unsigned DEP = 4;

  typedef logic [31:0] q_t [$];

  typedef struct {
    logic [31:0] pa;
    bit          va;
    int unsigned ca;
    logic [31:0] pb;
    bit          vb;
    int unsigned cb;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        jtag;
  logic        trap;
  logic [31:0] taddr;
  logic        jmp;
  logic [31:0] jaddr;
  logic        hold;
  logic        rdy;
  logic        il16;
  logic        call;
  logic        ret;

  logic [31:0] pc_a;
  logic        val_a;
  logic [2:0]  cnt_a;
  logic [31:0] pc_b;
  logic        val_b;
  logic [2:0]  cnt_b;

  int n_chk = 0;
  int n_fail = 0;

  exp_t        exp_q [$];
  logic [31:0] m_pc_a;
  bit          m_run_a;
  q_t          m_ras_a;
  logic [31:0] m_pc_b;
  bit          m_run_b;
  q_t          m_ras_b;

  always #5 clk = ~clk;

  panxi_pc_gen #(
    .DW(32), .RST_VEC(RV), .C_EXT(1), .RAS_DEPTH(DEP)
  ) dut_a (
    .clk(clk), .rst(rst), .rst_jtag_xi(jtag),
    .trap_en_xi(trap), .trap_addr_xi(taddr),
    .jmp_en_xi(jmp), .jmp_addr_xi(jaddr),
    .hold_xi(hold), .fetch_ready_xi(rdy),
    .ilen16_xi(il16), .call_xi(call), .ret_xi(ret),
    .pc_xo(pc_a), .pc_valid_xo(val_a), .ras_cnt_xo(cnt_a)
  );

  panxi_pc_gen #(
    .DW(32), .RST_VEC(RV), .C_EXT(0), .RAS_DEPTH(DEP)
  ) dut_b (
    .clk(clk), .rst(rst), .rst_jtag_xi(jtag),
    .trap_en_xi(trap), .trap_addr_xi(taddr),
    .jmp_en_xi(jmp), .jmp_addr_xi(jaddr),
    .hold_xi(hold), .fetch_ready_xi(rdy),
    .ilen16_xi(il16), .call_xi(call), .ret_xi(ret),
    .pc_xo(pc_b), .pc_valid_xo(val_b), .ras_cnt_xo(cnt_b)
  );

  function automatic logic [31:0] aln(input bit c, input logic [31:0] a);
    return c ? (a & ~32'h1) : (a & ~32'h3);
  endfunction

  // reference: PC as plain arithmetic, RAS as a bounded queue
  task automatic mstep(input bit c, inout logic [31:0] pc,
                       inout bit run, inout q_t ras);
    logic [31:0] seq;
    bit          acc;
    if (rst || jtag) begin
      pc  = RV;
      run = 0;
      ras.delete();
      return;
    end
    acc = run && rdy && !hold;
    seq = pc + ((c && il16) ? 32'd2 : 32'd4);
    if (trap) pc = aln(c, taddr);
    else if (jmp) pc = aln(c, jaddr);
    else if (acc) begin
      pc = seq;
      if (ret && ras.size() > 0) pc = aln(c, ras.pop_back());
      if (call) begin
        ras.push_back(seq);
        if (ras.size() > DEP) void'(ras.pop_front());
      end
    end
    run = 1;
  endtask

  task automatic tick();
    exp_t e;
    mstep(1'b1, m_pc_a, m_run_a, m_ras_a);
    mstep(1'b0, m_pc_b, m_run_b, m_ras_b);
    e.pa = m_pc_a; e.va = m_run_a; e.ca = m_ras_a.size();
    e.pb = m_pc_b; e.vb = m_run_b; e.cb = m_ras_b.size();
    exp_q.push_back(e);
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 0; jtag = 0; trap = 0; jmp = 0; hold = 0;
    rdy = 1; il16 = 0; call = 0; ret = 0;
    taddr = '0; jaddr = '0;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, req, $time);
    end
  endtask

  // monitor: compare DUT outputs against the oldest expectation
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("pc_a", pc_a, e.pa);
      chk("valid_a", 32'(val_a), 32'(e.va));
      chk("cnt_a", 32'(cnt_a), e.ca);
      chk("pc_b", pc_b, e.pb);
      chk("valid_b", 32'(val_b), 32'(e.vb));
      chk("cnt_b", 32'(cnt_b), e.cb);
    end
  end

  task automatic jump_to(input logic [31:0] a);
    idle(); jmp = 1; jaddr = a; tick(); idle();
  endtask

  initial begin
    idle();
    rst = 1;
    m_pc_a = RV; m_run_a = 0;
    m_pc_b = RV; m_run_b = 0;
    @(negedge clk); #1;
    // reset sequencing
    repeat (3) tick();
    idle();
    repeat (4) tick();
    // trap outranks jump, both override hold
    idle(); hold = 1; trap = 1; taddr = 32'h100;
    jmp = 1; jaddr = 32'h200; tick();
    idle(); hold = 1; jmp = 1; jaddr = 32'h203; tick();
    // compressed steps
    jump_to(32'h10);
    il16 = 1; tick();
    il16 = 0; tick();
    il16 = 1; tick();
    // RAS push/pop and pop on empty
    jump_to(32'h40);
    call = 1; tick();
    jump_to(32'h80);
    call = 1; tick();
    jump_to(32'h300);
    ret = 1; tick();
    ret = 1; tick();
    ret = 1; tick();
    idle();
    // overflow: five pushes into four entries, then drain
    call = 1; repeat (5) tick();
    idle(); ret = 1; repeat (5) tick();
    // call and ret together, empty then non-empty
    idle(); call = 1; ret = 1; repeat (2) tick();
    // stall by ready and by hold
    idle(); rdy = 0; repeat (3) tick();
    idle(); hold = 1; repeat (2) tick();
    // address wrap
    jump_to(32'hFFFF_FFFC);
    tick();
    // debug reset mid-run with two RAS entries
    idle(); call = 1; repeat (2) tick();
    idle(); jtag = 1; tick();
    idle(); repeat (3) tick();
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst   = ($urandom_range(0, 199) == 0);
      jtag  = ($urandom_range(0, 149) == 0);
      trap  = ($urandom_range(0, 29) == 0);
      jmp   = ($urandom_range(0, 9) == 0);
      taddr = $urandom;
      jaddr = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 | 32'($urandom_range(0, 15)) : $urandom;
      hold  = ($urandom_range(0, 5) == 0);
      rdy   = ($urandom_range(0, 4) != 0);
      il16  = $urandom_range(0, 1) == 1;
      call  = ($urandom_range(0, 3) == 0);
      ret   = ($urandom_range(0, 3) == 0);
      tick();
    end
    idle();
    tick();
    @(negedge clk);
    #1;
    chk("drain", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
